// File: rtl/bmp_pkg.sv
// Shared constants and helpers for the BMP pixel unpacker: byte geometry of
// the packed input words, the pixel buffer and whole frames.
package bmp_pkg;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int WORD_BYTES      = 8;
  localparam int BUF_BYTES       = 10;
  localparam int CNT_W           = 4;

  function automatic int frame_bytes(input int width, input int height);
    return width * height * BYTES_PER_PIXEL;
  endfunction

endpackage

// File: rtl/bmp_pixel_unpack_if.sv
// Stream bundle for the unpacker: 64-bit packed byte words in, 24-bit RGB
// pixels with frame markers out. The unpacker takes the slave view.
interface bmp_pixel_unpack_if;

  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  modport slave (
    input  s_data, s_valid, pix_ready,
    output s_ready, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
  );

  modport master (
    output s_data, s_valid, pix_ready,
    input  s_ready, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
  );

endinterface

// File: rtl/bmp_pixel_counter.sv
// Raster position tracker: x runs 0..WIDTH-1 along a line, y runs
// 0..HEIGHT-1 down the frame, both stepping only when advance is high.
module bmp_pixel_counter #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sol,
  output logic          eol,
  output logic          eof
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last, y_last;

  assign x_last = (x_q == XW'(WIDTH - 1));
  assign y_last = (y_q == YW'(HEIGHT - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x   = x_q;
  assign y   = y_q;
  assign sol = (x_q == '0);
  assign eol = x_last;
  assign eof = x_last && y_last;

endmodule

// File: rtl/bmp_pixel_unpack.sv
// Unpacks 64-bit words of BMP bitmap bytes (BGR order) into one {R,G,B}
// pixel per handshake, tagging start of frame, end of line and end of frame.
module bmp_pixel_unpack
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic              clk,
  input  logic              reset,
  bmp_pixel_unpack_if.slave io
);

  localparam int BUF_W = BUF_BYTES * 8;
  localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  // A frame must end on a word boundary so the buffer is empty after eof.
  if ((frame_bytes(WIDTH, HEIGHT) % WORD_BYTES) != 0) begin : g_frame_size_check
    $fatal(1, "bmp_pixel_unpack: WIDTH*HEIGHT*3 must be a multiple of 8");
  end

  logic [BUF_W-1:0] buf_q, buf_d, buf_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_shift;
  logic             pix_valid, pix_fire, s_ready, word_fire;
  logic [XW-1:0]    x_unused;
  logic [YW-1:0]    y;
  logic             sol, eol, eof;

  assign pix_valid = !reset && (cnt_q >= CNT_W'(BYTES_PER_PIXEL));
  assign pix_fire  = pix_valid && io.pix_ready;
  // Accepting a word needs room for 8 more bytes after this cycle's pixel.
  assign s_ready   = !reset && ((cnt_q <= CNT_W'(2)) ||
                                ((cnt_q <= CNT_W'(5)) && pix_fire));
  assign word_fire = io.s_valid && s_ready;

  always_comb begin
    buf_shift = buf_q;
    cnt_shift = cnt_q;
    if (pix_fire) begin
      buf_shift = buf_q >> (8 * BYTES_PER_PIXEL);
      cnt_shift = cnt_q - CNT_W'(BYTES_PER_PIXEL);
    end
    buf_d = buf_shift;
    cnt_d = cnt_shift;
    // Bytes above cnt are always zero, so the new word can be OR-ed in place.
    if (word_fire) begin
      buf_d = buf_shift | (BUF_W'(io.s_data) << {cnt_shift, 3'b000});
      cnt_d = cnt_shift + CNT_W'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  bmp_pixel_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .advance (pix_fire),
    .x       (x_unused),
    .y       (y),
    .sol     (sol),
    .eol     (eol),
    .eof     (eof)
  );

  assign io.s_ready   = s_ready;
  assign io.pix_valid = pix_valid;
  assign io.pix_data  = buf_q[23:0];
  assign io.pix_sof   = pix_valid && sol && (y == '0);
  assign io.pix_eol   = pix_valid && eol;
  assign io.pix_eof   = pix_valid && eof;

endmodule

// File: doc/bmp_pixel_unpack.md
BMP_PIXEL_UNPACK -- requirements
Module: bmp_pixel_unpack

Interface
REQ-001 SHALL have parameter WIDTH, default 320, meaning pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 240, meaning lines per frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port s_data, input, 64 bits: packed BMP bitmap bytes; byte k sits in bits [8k+7:8k], and byte 0 comes first in file order.
REQ-006 SHALL have port s_valid, input, 1 bit: s_data valid.
REQ-007 SHALL have port s_ready, output, 1 bit: word accepted when s_valid and s_ready are both 1.
REQ-008 SHALL have port pix_data, output, 24 bits: one pixel as {R,G,B}.
REQ-009 SHALL have port pix_valid, output, 1 bit: pixel valid.
REQ-010 SHALL have port pix_ready, input, 1 bit: pixel consumed when pix_valid and pix_ready are both 1.
REQ-011 SHALL have port pix_sof, output, 1 bit: first pixel of frame (x=0, y=0).
REQ-012 SHALL have port pix_eol, output, 1 bit: last pixel of line (x=WIDTH-1).
REQ-013 SHALL have port pix_eof, output, 1 bit: last pixel of frame (x=WIDTH-1, y=HEIGHT-1).

Function
REQ-014 SHALL hold incoming bytes in an 80-bit byte buffer with a byte count cnt in the range 0..10.
REQ-015 SHALL drive pix_valid = (cnt >= 3), decoded from registered state only.
REQ-016 SHALL drive pix_data = {buf byte2, buf byte1, buf byte0}, giving BGR-to-RGB order; this is combinational from the buffer.
REQ-017 SHALL drive s_ready = !reset && (cnt <= 2 || (cnt <= 5 && pix_valid && pix_ready)).
REQ-018 SHALL, on a pixel handshake, shift the buffer down 3 bytes and reduce cnt by 3.
REQ-019 SHALL, on a word handshake, append the 8 new bytes directly above the remaining bytes and increase cnt by 8.
REQ-020 SHALL, when both handshakes occur in the same cycle, apply the shift first and the append second, so cnt_next = cnt - 3 + 8.
REQ-021 SHALL have a latency of 1 cycle from an accepted word to pix_valid.
REQ-022 SHALL sustain 1 pixel per cycle while input is available.
REQ-023 SHALL, while pix_valid is 1 and pix_ready is 0, hold pix_data, pix_sof, pix_eol and pix_eof stable.
REQ-024 SHALL keep x and y counters that advance only on a pixel handshake: x wraps at WIDTH-1 and then increments y; y wraps at HEIGHT-1, returning to 0,0.
REQ-025 SHALL drive pix_sof, pix_eol and pix_eof combinationally from x and y, qualified by pix_valid.
REQ-026 SHALL require WIDTH*HEIGHT*3 to be a multiple of 8, checked at elaboration with a fatal error otherwise; as a result cnt is 0 after every pix_eof handshake.
REQ-027 SHALL perform no BMP row padding or row-order handling; the header is stripped upstream.

Reset
REQ-028 SHALL, while reset is 1 at a clock edge, clear cnt, buf, x and y to 0.
REQ-029 SHALL, while reset is asserted, drive s_ready=0 and pix_valid=0, which also forces pix_sof, pix_eol and pix_eof to 0.
REQ-030 SHALL treat reset mid-frame as discarding buffered bytes; the next pixel after reset carries pix_sof=1.

Structure
REQ-031 SHALL place in shared package bmp_pkg the constants BYTES_PER_PIXEL=3, WORD_BYTES=8 and BUF_BYTES=10, plus a function computing frame byte count.
REQ-032 SHALL put the x/y position counting in one sub-module, bmp_pixel_counter, with inputs advance and reset and outputs x, y, sol, eol and eof.

Verification
Benches SHALL use WIDTH=8 and HEIGHT=2, giving 48 bytes = 6 words = 16 pixels.
REQ-033 SHALL cover: after reset, send word 64'h0706050403020100 with pix_ready=1 -> pixels 24'h020100 (sof=1), then 24'h050403; cnt=2; s_ready=1; word 64'h0F0E0D0C0B0A0908 -> next pixel 24'h080706.
REQ-034 SHALL cover: full frame with s_valid=1 and pix_ready=1 throughout -> 16 pixels; eol on pixels 7 and 15; eof only on pixel 15; s_ready low on the cycles where cnt is greater than 5; cnt=0 at frame end.
REQ-035 SHALL cover: pix_ready=0 after the first word -> pix_valid=1, pix_data=24'h020100 held; s_ready=0 because cnt=8; no data lost once pix_ready returns to 1.
REQ-036 SHALL cover: reset asserted after pixel 5 for 1 cycle -> s_ready=0 and pix_valid=0 during reset; the next frame's first pixel has sof=1 and equals bytes 2,1,0 of the new word.
REQ-037 SHALL cover: two back-to-back frames -> pixel 16 carries sof=1, with no gap cycles beyond the input rate.
REQ-038 SHALL cover: random s_valid/pix_ready toggling over 4 frames -> output byte stream equals input byte stream, scoreboard-compared.
